aes_block_packer: RTL and testbench
===================================

# aes_block_packer

Input-side stage of the AES HWPE engine. It sits between the source stream of the streamer and the cipher core, and is controlled by the engine control word that the control unit emits. It packs 32-bit stream beats into 128-bit AES state blocks and hands them to the core over a valid/ready handshake. It counts delivered blocks against a job length and returns busy/done flags to the control FSM.

## Interface
Parameters:
- N_BLOCKS_W, 16, width of the job-length field and of the block counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; asynchronous and active-low.
- clear_i  in  1  synchronous clear from the control slave; returns all state to reset values.
- start_i  in  1  one-cycle job start from the control FSM.
- n_blocks_i  in  N_BLOCKS_W  number of 128-bit blocks in the job; sampled when start_i is accepted.
- in_valid_i  in  1  source beat valid.
- in_ready_o  out  1  source beat ready.
- in_data_i  in  32  source beat data.
- out_valid_o  out  1  packed block valid.
- out_ready_i  in  1  core accepts block.
- out_data_o  out  128  packed block.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle job-complete pulse.
- blk_cnt_o  out  N_BLOCKS_W  blocks delivered in the current or last job.

## Operation
- Reset and clear_i values: in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0, blk_cnt_o=0, state IDLE.
- clear_i has priority over every other input in the same cycle.
- IDLE:
  - On start_i with n_blocks_i≠0: latch n_blocks_i, zero blk_cnt_o and the 2-bit word counter, then go to FILL.
  - On start_i with n_blocks_i=0: go directly to DONE.
- FILL:
  - in_ready_o=1 and busy_o=1.
  - Each accepted beat (in_valid_i & in_ready_o) goes into word slot w = word counter, then the counter increments.
  - Slot w occupies out_data_o[127-32w -: 32]. The first beat lands in bits [127:96] (FIPS-197 column 0).
  - Accepting the beat at w=3 moves the block to HOLD.
- HOLD:
  - out_valid_o=1, in_ready_o=0, busy_o=1.
  - out_data_o stays stable until out_ready_i is sampled high.
  - On handshake, blk_cnt_o increments.
  - If the new count equals the latched length, go to DONE. Otherwise go to FILL with the word counter at 0.
- DONE:
  - done_o=1 for exactly one cycle and busy_o=0, then return to IDLE.
  - blk_cnt_o holds its value until the next start.
- start_i outside IDLE is ignored.
- in_valid_i outside FILL is not acknowledged. Beats are never dropped or duplicated.
- Width rules:
  - blk_cnt_o compares against the latched n_blocks_i.
  - The counter never wraps, because the maximum job is 2^N_BLOCKS_W−1 blocks.
  - The word counter wraps 3→0 only when a block completes.

## Timing
- Start to in_ready_o high: 1 cycle.
- The 4th accepted beat is followed by out_valid_o high on the next cycle.
- Minimum period is 5 cycles per block: 4 fill cycles plus 1 handshake cycle.
- With a continuously valid source and a continuously ready core, 2 blocks occupy cycles 1–10 after start, and done_o rises in cycle 11.
- The last block handshake at cycle t gives done_o=1 at t+1, and the block is in IDLE at t+2.
- busy_o is registered:
  - It goes high the cycle after start is accepted.
  - It goes low in the DONE cycle.
- Reset is asynchronous: asserting rst_ni low mid-job forces the reset values immediately.
- clear_i asserted mid-job aborts on the next edge. No done_o pulse is produced.

## Configuration
- AES_PACKER_BYTESWAP_EN:
  - When defined, each beat is byte-reversed before it is stored: in_data_i[7:0] goes to the slot's MSB byte, in_data_i[31:24] to its LSB byte. This supports little-endian memory images.
  - When undefined, beats are stored as-is.
  - Timing and handshakes are identical in both builds.

## Test plan
- Single block:
  - Stimulus: start, n_blocks=1; beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; core always ready.
  - Response: out_data_o=0x00112233_44556677_8899AABB_CCDDEEFF, valid 1 cycle, done_o pulse, blk_cnt_o=1.
- Core backpressure:
  - Stimulus: out_ready_i held low for 7 cycles in HOLD.
  - Response: out_data_o stable, in_ready_o=0 throughout, no beat consumed; after out_ready_i rises the next block fills correctly.
- Bubbled source and zero-length job:
  - Stimulus 1: n_blocks=3 with in_valid_i toggling every other cycle.
  - Response 1: 3 correctly ordered blocks, blk_cnt_o=3.
  - Stimulus 2: start with n_blocks=0.
  - Response 2: done_o one cycle later, out_valid_o never high.
- Abort:
  - Stimulus: clear_i after 2 beats of block 2 of 4.
  - Response: all outputs return to 0, no done_o pulse; a new start with n_blocks=1 works normally.
- Async reset and ignored start:
  - Stimulus 1: rst_ni low during HOLD.
  - Response 1: out_valid_o drops without waiting for a clock.
  - Stimulus 2: start_i during FILL.
  - Response 2: ignored, the latched length is unchanged.
- Byte swap (AES_PACKER_BYTESWAP_EN defined):
  - Stimulus: first beat 0x00112233.
  - Response: out_data_o[127:96]=0x33221100.

Source files
------------

// File: rtl/aes_block_packer.sv
// aes_block_packer: packs 32-bit source beats into 128-bit AES state blocks
// and delivers them to the cipher core, counting blocks against a job length.
// Optional build macro: AES_PACKER_BYTESWAP_EN (byte-reverse each beat before storing).
module aes_block_packer #(
  parameter int unsigned N_BLOCKS_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [N_BLOCKS_W-1:0] n_blocks_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [127:0]          out_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [N_BLOCKS_W-1:0] blk_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            word_q, word_d;
  logic [N_BLOCKS_W-1:0] len_q, len_d;
  logic [N_BLOCKS_W-1:0] cnt_q, cnt_d;
  logic [N_BLOCKS_W-1:0] cnt_inc;
  logic [127:0]          data_q, data_d;
  logic                  busy_q, busy_d;
  logic [31:0]           beat_word;

`ifdef AES_PACKER_BYTESWAP_EN
  // Little-endian memory images: the lowest byte of the beat becomes the slot MSB.
  assign beat_word = {in_data_i[7:0], in_data_i[15:8], in_data_i[23:16], in_data_i[31:24]};
`else
  assign beat_word = in_data_i;
`endif

  assign cnt_inc = cnt_q + N_BLOCKS_W'(1);

  // Next-state, slot write and block counting.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (n_blocks_i != '0) begin
            len_d   = n_blocks_i;
            cnt_d   = '0;
            word_d  = '0;
            state_d = FILL;
          end else begin
            state_d = DONE;
          end
        end
      end
      FILL: begin
        if (in_valid_i) begin
          // Slot 0 is the FIPS-197 column 0, i.e. the top 32 bits.
          case (word_q)
            2'd0:    data_d[127:96] = beat_word;
            2'd1:    data_d[95:64]  = beat_word;
            2'd2:    data_d[63:32]  = beat_word;
            default: data_d[31:0]   = beat_word;
          endcase
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready_i) begin
          cnt_d  = cnt_inc;
          word_d = '0;
          if (cnt_inc == len_q) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy is registered from the next state so it rises the cycle after start and drops in DONE.
  always_comb begin
    busy_d = (state_d == FILL) || (state_d == HOLD);
  end

  // State register with synchronous clear taking priority over all other inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      word_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= IDLE;
      word_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  // Handshake and status outputs decoded from the registered state.
  always_comb begin
    in_ready_o  = (state_q == FILL);
    out_valid_o = (state_q == HOLD);
    done_o      = (state_q == DONE);
    busy_o      = busy_q;
    out_data_o  = data_q;
    blk_cnt_o   = cnt_q;
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: transaction-level reference model
// (beat queue plus block/word counts) compared against the DUT every cycle.
module tb_aes_block_packer;

  localparam int W = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          clear_i = 1'b0;
  logic          start_i = 1'b0;
  logic [W-1:0]  n_blocks_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [31:0]   in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [127:0]  out_data_o;
  logic          busy_o;
  logic          done_o;
  logic [W-1:0]  blk_cnt_o;

  aes_block_packer #(.N_BLOCKS_W(W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .n_blocks_i  (n_blocks_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .blk_cnt_o   (blk_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] store_word(input logic [31:0] b);
`ifdef AES_PACKER_BYTESWAP_EN
    return {b[7:0], b[15:8], b[23:16], b[31:24]};
`else
    return b;
`endif
  endfunction

  // ---------------- reference model ----------------
  bit          m_active, m_hold, m_done;
  int          m_words, m_blocks, m_len;
  logic [31:0] m_q[$];
  int          beats_acc = 0;

  function automatic logic [127:0] model_block();
    return {store_word(m_q[0]), store_word(m_q[1]), store_word(m_q[2]), store_word(m_q[3])};
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      m_active = 0; m_hold = 0; m_done = 0;
      m_words = 0; m_blocks = 0; m_len = 0;
      m_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (start_i) begin
        if (n_blocks_i == '0) begin
          m_done = 1;
        end else begin
          m_active = 1; m_len = int'(n_blocks_i); m_blocks = 0; m_words = 0;
        end
      end
    end else if (m_hold) begin
      if (out_ready_i) begin
        m_blocks++;
        repeat (4) void'(m_q.pop_front());
        m_hold = 0;
        if (m_blocks == m_len) begin
          m_active = 0; m_done = 1;
        end
      end
    end else if (in_valid_i) begin
      m_q.push_back(in_data_i);
      beats_acc++;
      m_words++;
      if (m_words == 4) begin
        m_words = 0; m_hold = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("in_ready", in_ready_o, m_active && !m_hold);
      chk("out_valid", out_valid_o, m_hold);
      chk("busy", busy_o, m_active);
      chk("done", done_o, m_done);
      chk("blk_cnt", blk_cnt_o, m_blocks[W-1:0]);
      if (m_hold) chk("out_data", out_data_o, model_block());
    end
  end

  // ---------------- stimulus ----------------
  int          valid_mode, ready_mode, hold_cnt, start_cyc, done_cyc, beat_base, inject_at;
  bit          use_tab;
  logic [31:0] tab [4];
  logic [127:0] last_blk;

  task automatic drive_cycle();
    if (use_tab) in_data_i = tab[(beats_acc - beat_base) % 4];
    else         in_data_i = $urandom;
    case (valid_mode)
      0:       in_valid_i = 1'b1;
      1:       in_valid_i = 1'($urandom_range(0, 1));
      default: in_valid_i = ~in_valid_i;
    endcase
    case (ready_mode)
      0: out_ready_i = 1'b1;
      1: out_ready_i = 1'($urandom_range(0, 1));
      2: begin
        if (hold_cnt >= 7) out_ready_i = 1'b1;
        else if (out_valid_o) begin out_ready_i = 1'b0; hold_cnt++; end
        else out_ready_i = 1'b0;
      end
      default: out_ready_i = 1'b0;
    endcase
    if (inject_at != 0 && cyc == start_cyc + inject_at) begin
      start_i = 1'b1; n_blocks_i = W'(7);
    end
  endtask

  task automatic start_job(input int n, input int vm, input int rm);
    @(negedge clk_i);
    valid_mode = vm; ready_mode = rm; hold_cnt = 0; beat_base = beats_acc;
    start_i = 1'b1; n_blocks_i = W'(n); start_cyc = cyc;
    in_valid_i = 1'b0;
  endtask

  task automatic run_job(input int n, input int vm, input int rm, input int budget);
    bit timeout;
    start_job(n, vm, rm);
    timeout = 1;
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (out_valid_o && out_ready_i) last_blk = out_data_o;
      if (done_o) begin done_cyc = cyc; timeout = 0; break; end
      drive_cycle();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0; inject_at = 0;
    if (timeout) chk("job_timeout", 1'b1, 1'b0);
  endtask

  initial begin
    int ndone;
    logic [127:0] exp1;
    inject_at = 0; use_tab = 0;
    tab[0] = 32'h00112233; tab[1] = 32'h44556677; tab[2] = 32'h8899AABB; tab[3] = 32'hCCDDEEFF;
`ifdef AES_PACKER_BYTESWAP_EN
    exp1 = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
`else
    exp1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
`endif

    // Reset values
    #3 rst_ni = 1'b0;
    #1;
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_data", out_data_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_blk_cnt", blk_cnt_o, '0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Single block with the known vector
    use_tab = 1;
    run_job(1, 0, 0, 50);
    use_tab = 0;
    chk("single_block_data", last_blk, exp1);
    chk("single_block_done_latency", 32'(done_cyc - start_cyc), 32'd6);
    @(negedge clk_i);
    chk("single_block_cnt", blk_cnt_o, W'(1));

    // Two back-to-back blocks: done_o in cycle 11
    run_job(2, 0, 0, 50);
    chk("two_block_done_cycle", 32'(done_cyc - start_cyc), 32'd11);

    // Core backpressure: 7 held cycles in HOLD of the first block
    run_job(2, 0, 2, 80);
    chk("backpressure_done_cycle", 32'(done_cyc - start_cyc), 32'd18);

    // Bubbled source
    run_job(3, 2, 0, 100);
    @(negedge clk_i);
    chk("bubbled_cnt", blk_cnt_o, W'(3));

    // Zero-length job
    run_job(0, 0, 0, 10);
    chk("zero_len_done_cycle", 32'(done_cyc - start_cyc), 32'd1);

    // start_i during FILL is ignored
    inject_at = 2;
    run_job(2, 0, 0, 60);
    chk("ignored_start_done_cycle", 32'(done_cyc - start_cyc), 32'd11);
    @(negedge clk_i);
    chk("ignored_start_cnt", blk_cnt_o, W'(2));

    // Abort after 2 beats of block 2 of 4
    start_job(4, 0, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (m_blocks == 1 && m_words == 2) break;
      drive_cycle();
    end
    chk("abort_reached_point", 32'(m_blocks * 4 + m_words), 32'd6);
    clear_i = 1'b1; in_valid_i = 1'b0;
    @(negedge clk_i);
    clear_i = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o) ndone++;
      @(negedge clk_i);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_data_zero", out_data_o, '0);
    chk("abort_cnt_zero", blk_cnt_o, '0);
    chk("abort_busy_zero", busy_o, 1'b0);
    run_job(1, 0, 0, 50);
    @(negedge clk_i);
    chk("after_abort_cnt", blk_cnt_o, W'(1));

    // Asynchronous reset during HOLD
    start_job(1, 0, 3);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (out_valid_o) break;
      drive_cycle();
    end
    chk("areset_reached_hold", out_valid_o, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("areset_out_valid", out_valid_o, 1'b0);
    chk("areset_busy", busy_o, 1'b0);
    chk("areset_data", out_data_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      run_job(int'($urandom_range(1, 5)), 1, 1, 600);
    end
    repeat (3) @(negedge clk_i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
